pipe_reg_chain: RTL and testbench

- Parametrised successor to the fixed inter-stage pipeline flops of the pipelined ARM datapath.
- Implements STAGES chained pipeline registers (Decode→Execute→Memory→Writeback and beyond) with a per-stage valid bit, per-stage stall and flush, and bubble insertion.
- Also provides forwarding-select outputs for two source register addresses, so the hazard logic and the datapath share one structure.

---
 rtl/pipe_reg_chain.sv | 140 ++++++++++++++
 tb/tb_pipe_reg_chain.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: parametrised inter-stage pipeline registers with per-stage
// valid/regwrite, stall/flush/bubble control and two forwarding selects.

// One pipeline stage: flush > hold > bubble > load (reset applied in the flop).
module pipe_stage #(
    parameter int WIDTH = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             hold,
    input  logic             up_hold,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_valid,
    input  logic             up_regwrite,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             regwrite
);
    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;
    logic             regwrite_d, regwrite_q;

    // Next-state selection for this stage.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        if (flush || (!hold && up_hold)) begin
            data_d     = '0;
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
        end else if (!hold) begin
            data_d     = up_data;
            valid_d    = up_valid;
            regwrite_d = up_regwrite;
        end
    end

    // Stage flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
        end
    end

    assign data     = data_q;
    assign valid    = valid_q;
    assign regwrite = regwrite_q;
endmodule

module pipe_reg_chain #(
    parameter int WIDTH   = 100,
    parameter int STAGES  = 3,
    parameter int AW      = 4,
    parameter int WA_LSB  = 96,
    parameter int PC_ADDR = 15,
    parameter int SELW    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    input  logic                     in_regwrite,
    input  logic [STAGES-1:0]        stall,
    input  logic [STAGES-1:0]        flush,
    input  logic [AW-1:0]            ra1,
    input  logic [AW-1:0]            ra2,
    output logic [STAGES*WIDTH-1:0]  stage_data,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES-1:0]        stage_regwrite,
    output logic [SELW-1:0]          fwd1,
    output logic [SELW-1:0]          fwd2,
    output logic                     in_ready
);
    logic [STAGES-1:0][WIDTH-1:0] data_s;
    logic [STAGES-1:0][WIDTH-1:0] up_data;
    logic [STAGES-1:0]            up_valid, up_regwrite, up_hold;
    logic [STAGES-1:0]            hold;

    // A stall anywhere downstream freezes every stage at or above it.
    always_comb begin
        hold = '0;
        hold[STAGES-1] = stall[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--)
            hold[k] = hold[k+1] | stall[k];
    end

    assign in_ready = ~hold[0];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign up_data[g]     = in_data;
            assign up_valid[g]    = in_valid;
            assign up_regwrite[g] = in_regwrite & in_valid;
            assign up_hold[g]     = 1'b0;
        end else begin : g_body
            assign up_data[g]     = data_s[g-1];
            assign up_valid[g]    = stage_valid[g-1];
            assign up_regwrite[g] = stage_regwrite[g-1];
            assign up_hold[g]     = hold[g-1];
        end

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk         (clk),
            .reset       (reset),
            .flush       (flush[g]),
            .hold        (hold[g]),
            .up_hold     (up_hold[g]),
            .up_data     (up_data[g]),
            .up_valid    (up_valid[g]),
            .up_regwrite (up_regwrite[g]),
            .data        (data_s[g]),
            .valid       (stage_valid[g]),
            .regwrite    (stage_regwrite[g])
        );
    end

    assign stage_data = data_s;

    // Forward selects from registered state; scanning oldest to youngest lets the youngest win.
    always_comb begin
        fwd1 = '0;
        fwd2 = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (stage_valid[k] && stage_regwrite[k]) begin
                if (data_s[k][WA_LSB +: AW] == ra1 && ra1 != AW'(PC_ADDR))
                    fwd1 = SELW'(k + 1);
                if (data_s[k][WA_LSB +: AW] == ra2 && ra2 != AW'(PC_ADDR))
                    fwd2 = SELW'(k + 1);
            end
        end
    end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: directed test-plan steps followed by
// randomized traffic, all checked against a rule-level reference model.
module tb_pipe_reg_chain;
    localparam int S  = 3;
    localparam int W  = 100;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [W-1:0]      in_data = '0;
    logic              in_valid = 1'b0, in_regwrite = 1'b0;
    logic [S-1:0]      stall = '0, flush = '0;
    logic [AW-1:0]     ra1 = '0, ra2 = '0;
    logic [S*W-1:0]    stage_data;
    logic [S-1:0]      stage_valid, stage_regwrite;
    logic [3:0]        fwd1, fwd2;
    logic              in_ready;

    int total = 0;
    int bad   = 0;

    // Reference model state: one entry per stage.
    logic [W-1:0] md [S];
    bit           mv [S];
    bit           mr [S];

    pipe_reg_chain #(.WIDTH(W), .STAGES(S), .AW(AW), .WA_LSB(96), .PC_ADDR(15), .SELW(4)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_regwrite(in_regwrite), .stall(stall), .flush(flush), .ra1(ra1), .ra2(ra2),
        .stage_data(stage_data), .stage_valid(stage_valid), .stage_regwrite(stage_regwrite),
        .fwd1(fwd1), .fwd2(fwd2), .in_ready(in_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [S*W-1:0] obs, input logic [S*W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest valid writing stage whose destination matches, r15 never forwarded.
    function automatic int fwd_of(input logic [AW-1:0] ra);
        if (ra == 4'd15) return 0;
        for (int k = 0; k < S; k++)
            if (mv[k] && mr[k] && md[k][99:96] == ra) return k + 1;
        return 0;
    endfunction

    task automatic check_all();
        logic [S*W-1:0] ed;
        logic [S-1:0]   ev, er;
        for (int k = 0; k < S; k++) begin
            ed[k*W +: W] = md[k];
            ev[k] = mv[k];
            er[k] = mr[k];
        end
        chk("data", stage_data, ed);
        chk("valid", S*W'(stage_valid), S*W'(ev));
        chk("regwrite", S*W'(stage_regwrite), S*W'(er));
        chk("fwd1", S*W'(fwd1), S*W'(fwd_of(ra1)));
        chk("fwd2", S*W'(fwd2), S*W'(fwd_of(ra2)));
        chk("in_ready", S*W'(in_ready), S*W'(stall == '0));
    endtask

    // Advance the model by one edge using the current inputs, then compare.
    task automatic tick();
        logic [W-1:0] nd [S];
        bit           nv [S];
        bit           nr [S];
        for (int k = 0; k < S; k++) begin
            bit held    = (stall >> k) != 0;
            bit up_held = (k > 0) && ((stall >> (k - 1)) != 0);
            nd[k] = md[k]; nv[k] = mv[k]; nr[k] = mr[k];
            if (reset || flush[k] || (!held && up_held)) begin
                nd[k] = '0; nv[k] = 0; nr[k] = 0;
            end else if (!held) begin
                if (k == 0) begin
                    nd[k] = in_data; nv[k] = in_valid; nr[k] = in_valid & in_regwrite;
                end else begin
                    nd[k] = md[k-1]; nv[k] = mv[k-1]; nr[k] = mr[k-1];
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < S; k++) begin
            md[k] = nd[k]; mv[k] = nv[k]; mr[k] = nr[k];
        end
        check_all();
    endtask

    task automatic push(input logic [W-1:0] d, input logic v, input logic rw);
        in_data = d; in_valid = v; in_regwrite = rw;
    endtask

    function automatic logic [W-1:0] mk(input logic [3:0] wa);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        r[99:96] = wa;
        return r[W-1:0];
    endfunction

    initial begin
        for (int k = 0; k < S; k++) begin md[k] = '0; mv[k] = 0; mr[k] = 0; end

        // Reset holds everything at zero.
        reset = 1'b1;
        tick(); tick();
        chk("reset_valid", S*W'(stage_valid), '0);
        reset = 1'b0;

        // Stream 0xA, 0xB, 0xC.
        push('hA, 1, 1); tick();
        push('hB, 1, 1); tick();
        push('hC, 1, 1); tick();
        chk("stream_s2_A", S*W'(stage_data[2*W +: W]), S*W'('hA));
        push('0, 0, 0); tick();
        chk("stream_s2_B", S*W'(stage_data[2*W +: W]), S*W'('hB));
        tick();
        chk("stream_s2_C", S*W'(stage_data[2*W +: W]), S*W'('hC));

        // Stall stage 1 for two cycles while streaming.
        push('h11, 1, 1); tick();
        push('h12, 1, 1); tick();
        stall = 3'b010;
        push('h13, 1, 1); tick();
        chk("stall_ready", S*W'(in_ready), '0);
        tick();
        chk("stall_bubble_v", S*W'(stage_valid[2]), '0);
        chk("stall_s1_hold", S*W'(stage_data[W +: W]), S*W'('h11));
        stall = '0;
        tick(); tick();
        chk("resume_s2", S*W'(stage_data[2*W +: W]), S*W'('h12));
        push('0, 0, 0); tick();
        chk("resume_s2_next", S*W'(stage_data[2*W +: W]), S*W'('h13));

        // Flush stage 1 while stage 2 is stalled.
        push('h21, 1, 1); tick();
        push('h22, 1, 1); tick();
        push('h23, 1, 1); tick();
        stall = 3'b100; flush = 3'b010;
        tick();
        chk("flush_s1_v", S*W'(stage_valid[1]), '0);
        chk("flush_s2_hold", S*W'(stage_data[2*W +: W]), S*W'('h21));
        chk("flush_s0_hold", S*W'(stage_data[0 +: W]), S*W'('h23));
        stall = '0; flush = '0;

        // Forward priority: stage 0 and stage 2 both write r3.
        push(mk(4'd3), 1, 1); tick();
        push(mk(4'd7), 1, 1); tick();
        push(mk(4'd3), 1, 1); tick();
        ra1 = 4'd3; ra2 = 4'd5; push('0, 0, 0);
        #1 check_all();
        chk("fwd_young", S*W'(fwd1), S*W'(1));
        stall = 3'b100; flush = 3'b001;
        tick();
        chk("fwd_old", S*W'(fwd1), S*W'(3));
        chk("fwd_none", S*W'(fwd2), '0);
        stall = '0; flush = '0;

        // PC exclusion and invalid-stage match.
        ra1 = 4'd15; ra2 = 4'd9;
        push(mk(4'd15), 1, 1); tick();
        chk("fwd_pc", S*W'(fwd1), '0);
        push(mk(4'd9), 0, 1); tick();
        chk("fwd_invalid", S*W'(fwd2), '0);

        // Reset while stage 2 is stalled and every stage is valid.
        push(mk(4'd1), 1, 1); tick(); tick(); tick();
        stall = 3'b100; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_stall_valid", S*W'(stage_valid), '0);
        chk("rst_stall_data", stage_data, '0);
        chk("rst_stall_ready", S*W'(in_ready), '0);
        stall = '0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            push(mk(4'($urandom_range(0, 15))), 1'($urandom_range(0, 3) != 0), 1'($urandom));
            stall = ($urandom_range(0, 3) == 0) ? S'($urandom) : '0;
            flush = ($urandom_range(0, 5) == 0) ? S'($urandom) : '0;
            reset = ($urandom_range(0, 60) == 0);
            ra1 = 4'($urandom_range(0, 15));
            ra2 = 4'($urandom_range(0, 15));
            tick();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
